// File: rtl/uart_tx.sv
// Register-mapped 8N1 UART transmitter with a small byte FIFO.
// Bridge sees DATA/CTRL/DIV/STATUS; tx is a registered serial line.
module uart_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Addr,
    input  logic        Write_Enabled,
    input  logic [31:0] Data_In,
    output logic [31:0] Data_Out,
    output logic        INT_REQ,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic        txen;
    logic        irqen;
    logic        ovf;
    logic [15:0] div;
    logic [15:0] div_lat;
    logic [15:0] baud;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        tx_next;

    logic wr_data;
    logic wr_ctrl;
    logic wr_div;
    logic wr_status;
    logic empty;
    logic full;
    logic busy;
    logic push;
    logic pop;
    logic start_ok;
    logic bit_end;
    logic [2:0] cnt3;
    logic unused_bits;

    assign wr_data   = Write_Enabled && (Addr == 2'd0);
    assign wr_ctrl   = Write_Enabled && (Addr == 2'd1);
    assign wr_div    = Write_Enabled && (Addr == 2'd2);
    assign wr_status = Write_Enabled && (Addr == 2'd3);

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign busy     = (state != IDLE);
    assign push     = wr_data && !full;
    assign start_ok = txen && !empty;
    assign bit_end  = (baud == div_lat - 16'd1);
    // A pop only ever happens when a new frame starts.
    assign pop      = start_ok &&
                      ((state == IDLE) || ((state == STOP) && bit_end));

    assign INT_REQ     = irqen && empty && !busy;
    assign cnt3        = 3'(count);
    assign unused_bits = ^Data_In[31:16];

    always_comb begin
        Data_Out = '0;
        case (Addr)
            2'd0: Data_Out = '0;
            2'd1: Data_Out = {30'b0, irqen, txen};
            2'd2: Data_Out = {16'b0, div};
            2'd3: Data_Out = {25'b0, ovf, cnt3, empty, full, busy};
            default: Data_Out = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txen  <= 1'b0;
            irqen <= 1'b0;
            div   <= DIV_RESET;
            ovf   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                txen  <= Data_In[0];
                irqen <= Data_In[1];
            end
            if (wr_div) begin
                div <= (Data_In[15:0] == 16'd0) ? 16'd1 : Data_In[15:0];
            end
            if (wr_status) begin
                ovf <= 1'b0;
            end else if (wr_data && full) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= Data_In[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start_ok) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && (bit_cnt == 3'd7)) state_next = STOP;
            STOP:  if (bit_end) state_next = start_ok ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next = tx;
        unique case (state)
            IDLE:  tx_next = !pop;
            START: if (bit_end) tx_next = shift[0];
            DATA:  if (bit_end) tx_next = (bit_cnt == 3'd7) ? 1'b1 : shift[1];
            STOP:  if (bit_end) tx_next = !pop;
            default: tx_next = 1'b1;
        endcase
    end

    // Divisor is latched at pop so DIV writes only affect later frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx      <= 1'b1;
            shift   <= '0;
            div_lat <= 16'd1;
            baud    <= '0;
            bit_cnt <= '0;
        end else begin
            tx <= tx_next;
            if (pop) begin
                shift   <= mem[rd_ptr];
                div_lat <= div;
                baud    <= '0;
                bit_cnt <= '0;
            end else if (state != IDLE) begin
                if (bit_end) begin
                    baud <= '0;
                    if (state == DATA) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end else begin
                    baud <= baud + 16'd1;
                end
            end
        end
    end

endmodule
